// File: rtl/fifo_rd_packer_pkg.sv
// Shared types and helpers for the FIFO read-side packer.
// Holds the FSM state encoding, the lane-keep mask helper and the default word width.
package fifo_rd_packer_pkg;

  localparam int DW_DEF   = 4;
  localparam int PACK_DEF = 4;

  typedef enum logic {
    S_FILL  = 1'b0,
    S_FLUSH = 1'b1
  } state_e;

  // Low cnt lanes set; callers truncate to their lane count.
  function automatic logic [31:0] keep_mask(input logic [31:0] cnt);
    return (32'd1 << cnt) - 32'd1;
  endfunction

endpackage

// File: rtl/fifo_rd_packer_if.sv
// FIFO read port plus packed output stream seen by fifo_rd_packer.
// master = the packer side, slave = the FIFO/downstream environment side.
interface fifo_rd_packer_if
  import fifo_rd_packer_pkg::*;
#(
  parameter int DW   = DW_DEF,
  parameter int PACK = PACK_DEF
);
  localparam int ODW = DW * PACK;

  logic [DW-1:0]   fifo_dat;
  logic            fifo_empty;
  logic            fifo_ren;
  logic [ODW-1:0]  m_dat;
  logic [PACK-1:0] m_keep;
  logic            m_last;
  logic            m_valid;
  logic            m_ready;

  modport master (
    input  fifo_dat, fifo_empty, m_ready,
    output fifo_ren, m_dat, m_keep, m_last, m_valid
  );

  modport slave (
    output fifo_dat, fifo_empty, m_ready,
    input  fifo_ren, m_dat, m_keep, m_last, m_valid
  );
endinterface

// File: rtl/fifo_rd_packer.sv
// Packs PACK first-word-fall-through FIFO words into one valid/ready beat; flush emits a keep-masked partial beat.
// Full beat registers on the PACK-th pop edge; under backpressure the accumulator holds PACK-1 lanes and pops stall.
module fifo_rd_packer
  import fifo_rd_packer_pkg::*;
#(
  parameter int DW   = DW_DEF,
  parameter int PACK = PACK_DEF
)(
  input  logic             r_clk,
  input  logic             r_rstn,
  input  logic             flush,
  output logic             busy,
  fifo_rd_packer_if.master bus
);
  localparam int ODW = DW * PACK;
  localparam int CW  = (PACK > 1) ? $clog2(PACK) : 1;

  state_e          state;
  logic [ODW-1:0]  acc;
  logic [CW-1:0]   cnt;
  logic            flush_pend;
  logic [ODW-1:0]  m_dat_q;
  logic [PACK-1:0] m_keep_q;
  logic            m_last_q;
  logic            m_valid_q;

  logic out_free;
  logic cnt_full;
  logic pop;

  assign out_free = !m_valid_q || bus.m_ready;
  assign cnt_full = (cnt == CW'(PACK - 1));

  // The last lane may only be popped when the output register can take the beat.
  assign pop = r_rstn && (state == S_FILL) && !bus.fifo_empty && (!cnt_full || out_free);

  assign bus.fifo_ren = pop;
  assign bus.m_dat    = m_dat_q;
  assign bus.m_keep   = m_keep_q;
  assign bus.m_last   = m_last_q;
  assign bus.m_valid  = m_valid_q;

  assign busy = (cnt != '0) || m_valid_q || flush_pend;

  always_ff @(posedge r_clk or negedge r_rstn) begin
    if (!r_rstn) begin
      state      <= S_FILL;
      acc        <= '0;
      cnt        <= '0;
      flush_pend <= 1'b0;
      m_dat_q    <= '0;
      m_keep_q   <= '0;
      m_last_q   <= 1'b0;
      m_valid_q  <= 1'b0;
    end else begin
      // Default drop of valid after a transfer; a new beat load below overrides it.
      if (m_valid_q && bus.m_ready) begin
        m_valid_q <= 1'b0;
      end

      case (state)
        S_FILL: begin
          if (pop) begin
            if (!cnt_full) begin
              acc[int'(cnt)*DW +: DW] <= bus.fifo_dat;
              cnt                     <= cnt + CW'(1);
            end else begin
              m_dat_q   <= {bus.fifo_dat, acc[ODW-DW-1:0]};
              m_keep_q  <= '1;
              m_last_q  <= 1'b0;
              m_valid_q <= 1'b1;
              acc       <= '0;
              cnt       <= '0;
            end
          end
          if (flush || flush_pend) begin
            state      <= S_FLUSH;
            flush_pend <= 1'b1;
          end
        end

        S_FLUSH: begin
          // Further flush pulses here are absorbed into the pending one.
          if (out_free) begin
            if (cnt != '0) begin
              m_dat_q   <= acc;
              m_keep_q  <= PACK'(keep_mask(32'(cnt)));
              m_last_q  <= 1'b1;
              m_valid_q <= 1'b1;
            end
            acc        <= '0;
            cnt        <= '0;
            flush_pend <= 1'b0;
            state      <= S_FILL;
          end
        end

        default: state <= S_FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Self-checking bench for fifo_rd_packer: behavioural FIFO, queue-based packer model and word-stream scoreboard.
module tb_fifo_rd_packer;

  logic r_clk = 1'b0;
  logic r_rstn;
  logic flush;
  logic busy;

  always #5 r_clk = ~r_clk;

  fifo_rd_packer_if #(.DW(4), .PACK(4)) bus ();

  fifo_rd_packer #(.DW(4), .PACK(4)) dut (
    .r_clk  (r_clk),
    .r_rstn (r_rstn),
    .flush  (flush),
    .busy   (busy),
    .bus    (bus.master)
  );

  logic [3:0]  fq[$];          // FIFO contents, head = presented word
  logic [3:0]  sb[$];          // words expected to leave through the output, in order
  logic [3:0]  m_acc[$];       // model: words accumulated but not yet emitted
  bit          m_fl;           // model: flush pending
  bit          m_ov;           // model: output register valid
  logic [15:0] m_dat_e;
  logic [3:0]  m_keep_e;
  bit          m_last_e;

  logic [15:0] beat_dat[$];
  logic [3:0]  beat_keep[$];
  logic        beat_last[$];
  int          ren_cnt;
  int          n_chk;
  int          n_fail;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [3:0] w);
    fq.push_back(w);
    sb.push_back(w);
  endtask

  task automatic drive_fifo();
    bus.fifo_empty = (fq.size() == 0);
    bus.fifo_dat   = (fq.size() != 0) ? fq[0] : 4'h0;
  endtask

  task automatic clear_beats();
    beat_dat.delete();
    beat_keep.delete();
    beat_last.delete();
    ren_cnt = 0;
  endtask

  function automatic logic [15:0] lanes_of(input int n);
    logic [15:0] d;
    d = '0;
    for (int i = 0; i < n; i++) d[i*4 +: 4] = m_acc[i];
    return d;
  endfunction

  // One r_clk cycle: drive inputs, compare at negedge, advance model and FIFO at posedge.
  task automatic step(input bit rdy, input bit fl);
    bit          exp_ren;
    bit          ren_s;
    bit          out_free;
    logic [3:0]  w;
    bus.m_ready = rdy;
    flush       = fl;
    drive_fifo();
    @(negedge r_clk);
    exp_ren = !m_fl && (fq.size() != 0) && (m_acc.size() != 3 || !m_ov || rdy);
    check("fifo_ren", 32'(bus.fifo_ren), 32'(exp_ren));
    check("m_valid", 32'(bus.m_valid), 32'(m_ov));
    check("busy", 32'(busy), 32'((m_acc.size() != 0) || m_ov || m_fl));
    if (m_ov) begin
      check("m_dat", 32'(bus.m_dat), 32'(m_dat_e));
      check("m_keep", 32'(bus.m_keep), 32'(m_keep_e));
      check("m_last", 32'(bus.m_last), 32'(m_last_e));
    end
    if (bus.fifo_ren && bus.fifo_empty) check("ren_while_empty", 32'd1, 32'd0);
    ren_s = bus.fifo_ren;
    if (ren_s) ren_cnt++;
    if (bus.m_valid && rdy) begin
      beat_dat.push_back(bus.m_dat);
      beat_keep.push_back(bus.m_keep);
      beat_last.push_back(bus.m_last);
      for (int i = 0; i < 4; i++) begin
        if (bus.m_keep[i]) begin
          if (sb.size() == 0) check("sb_underflow", 32'(bus.m_dat[i*4 +: 4]), 32'hdead);
          else check("sb_word", 32'(bus.m_dat[i*4 +: 4]), 32'(sb.pop_front()));
        end
      end
    end
    @(posedge r_clk);
    w        = (fq.size() != 0) ? fq[0] : 4'h0;
    out_free = !m_ov || rdy;
    if (m_ov && rdy) m_ov = 0;
    if (!m_fl) begin
      if (exp_ren) begin
        m_acc.push_back(w);
        if (m_acc.size() == 4) begin
          m_dat_e  = lanes_of(4);
          m_keep_e = 4'hf;
          m_last_e = 0;
          m_ov     = 1;
          m_acc.delete();
        end
      end
      if (fl) m_fl = 1;
    end else if (out_free) begin
      if (m_acc.size() != 0) begin
        m_dat_e  = lanes_of(m_acc.size());
        m_keep_e = 4'((1 << m_acc.size()) - 1);
        m_last_e = 1;
        m_ov     = 1;
        m_acc.delete();
      end
      m_fl = 0;
    end
    #1;
    if (ren_s && fq.size() != 0) void'(fq.pop_front());
  endtask

  task automatic model_reset();
    m_acc.delete();
    m_fl = 0;
    m_ov = 0;
    fq.delete();
    sb.delete();
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    r_rstn = 1'b0;
    flush = 1'b0;
    bus.m_ready = 1'b0;
    model_reset();
    clear_beats();

    // Reset state, with words already waiting in the FIFO.
    for (int i = 1; i <= 4; i++) push(4'(i));
    drive_fifo();
    repeat (2) @(posedge r_clk);
    @(negedge r_clk);
    check("rst_m_valid", 32'(bus.m_valid), 32'd0);
    check("rst_m_dat", 32'(bus.m_dat), 32'd0);
    check("rst_m_keep", 32'(bus.m_keep), 32'd0);
    check("rst_m_last", 32'(bus.m_last), 32'd0);
    check("rst_ren", 32'(bus.fifo_ren), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    @(posedge r_clk);
    #1 r_rstn = 1'b1;

    // Full beat from 1,2,3,4.
    for (int i = 0; i < 8; i++) step(1, 0);
    check("t1_nbeats", 32'(beat_dat.size()), 32'd1);
    if (beat_dat.size() > 0) begin
      check("t1_dat", 32'(beat_dat[0]), 32'h4321);
      check("t1_keep", 32'(beat_keep[0]), 32'hf);
      check("t1_last", 32'(beat_last[0]), 32'd0);
    end
    check("t1_ren_cnt", 32'(ren_cnt), 32'd4);

    // Partial beat on flush.
    clear_beats();
    push(4'hA);
    push(4'hB);
    for (int i = 0; i < 3; i++) step(1, 0);
    step(1, 1);
    for (int i = 0; i < 4; i++) step(1, 0);
    check("t2_nbeats", 32'(beat_dat.size()), 32'd1);
    if (beat_dat.size() > 0) begin
      check("t2_dat", 32'(beat_dat[0]), 32'h00BA);
      check("t2_keep", 32'(beat_keep[0]), 32'h3);
      check("t2_last", 32'(beat_last[0]), 32'd1);
    end
    check("t2_busy_idle", 32'(busy), 32'd0);

    // Backpressure with 8 words queued.
    clear_beats();
    for (int i = 1; i <= 8; i++) push(4'(i));
    for (int i = 0; i < 10; i++) step(0, 0);
    check("t3_held_valid", 32'(bus.m_valid), 32'd1);
    check("t3_held_dat", 32'(bus.m_dat), 32'h4321);
    check("t3_stalled_ren", 32'(bus.fifo_ren), 32'd0);
    check("t3_fifo_left", 32'(fq.size()), 32'd1);
    for (int i = 0; i < 6; i++) step(1, 0);
    check("t3_nbeats", 32'(beat_dat.size()), 32'd2);
    if (beat_dat.size() > 1) begin
      check("t3_dat0", 32'(beat_dat[0]), 32'h4321);
      check("t3_dat1", 32'(beat_dat[1]), 32'h8765);
    end

    // Flush on the same edge as the 4th pop.
    clear_beats();
    for (int i = 5; i <= 8; i++) push(4'(i));
    for (int i = 0; i < 3; i++) step(1, 0);
    step(1, 1);
    for (int i = 0; i < 5; i++) step(1, 0);
    check("t4_nbeats", 32'(beat_dat.size()), 32'd1);
    if (beat_dat.size() > 0) begin
      check("t4_dat", 32'(beat_dat[0]), 32'h8765);
      check("t4_last", 32'(beat_last[0]), 32'd0);
    end

    // Asynchronous reset mid-beat: cnt=2 with a held full beat.
    clear_beats();
    for (int i = 1; i <= 6; i++) push(4'(i));
    for (int i = 0; i < 8; i++) step(0, 0);
    check("t5_pre_valid", 32'(bus.m_valid), 32'd1);
    check("t5_pre_busy", 32'(busy), 32'd1);
    #2 r_rstn = 1'b0;
    #1;
    check("t5_valid", 32'(bus.m_valid), 32'd0);
    check("t5_dat", 32'(bus.m_dat), 32'd0);
    check("t5_keep", 32'(bus.m_keep), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    model_reset();
    drive_fifo();
    repeat (2) @(posedge r_clk);
    #1 r_rstn = 1'b1;
    for (int i = 1; i <= 4; i++) push(4'(i));
    for (int i = 0; i < 7; i++) step(1, 0);
    check("t5_nbeats", 32'(beat_dat.size()), 32'd1);
    if (beat_dat.size() > 0) check("t5_after_dat", 32'(beat_dat[0]), 32'h4321);

    // Random traffic: 2^AW*2 words with AW=5, random m_ready and flush.
    begin
      int pushed;
      int cyc;
      pushed = 0;
      cyc = 0;
      while ((pushed < 64 || fq.size() != 0 || m_acc.size() != 0 || m_ov || m_fl) && cyc < 5000) begin
        if (pushed < 64 && $urandom_range(0, 2) != 0) begin
          push(4'($urandom_range(0, 15)));
          pushed++;
        end
        if (pushed >= 64 && fq.size() == 0 && m_acc.size() != 0 && !m_fl)
          step(1, 1);
        else
          step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 9) == 0));
        cyc++;
      end
      check("rand_timeout", 32'(cyc < 5000), 32'd1);
      check("rand_sb_drained", 32'(sb.size()), 32'd0);
      check("rand_fifo_drained", 32'(fq.size()), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
